alu_share_arbiter: RTL

- Shares one ALU instance between NUM_REQ requesters, e.g. the execute stage and a branch-compare unit.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants at most one operation per cycle.
- The ALU output is captured in a single response register, tagged with the granted requester ID, and held under rsp_ready backpressure.
- Sits between the issue logic and the shared ALU datapath.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_share_arbiter_alu.sv | 31 +++
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, illegal-op result and the response
// register state used by the ALU share arbiter.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_BEQ = 3'b101
  } alu_op_t;

  localparam logic [31:0] ALU_ILLEGAL_RESULT = 32'hDEADBEEF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational 32-bit ALU; zero is only meaningful for the BEQ
// compare, every other op reports zero=0.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    result = ALU_ILLEGAL_RESULT;
    zero   = 1'b0;
    case (sel)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, (a < b)};
      ALU_BEQ: begin
        result = a - b;
        zero   = (a == b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between NUM_REQ valid/ready requesters, with a
// single registered, ID-tagged response held under rsp_ready backpressure.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*3-1:0]   req_sel,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic [31:0]            busy_cnt
);

  rsp_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W:0]   pick;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            can_accept;
  logic            accept;
  logic [31:0]     alu_a, alu_b, alu_result;
  logic [2:0]      alu_sel;
  logic            alu_zero;

  // Returns {found, index} of the first valid requester at or after ptr,
  // scanning circularly; later loop iterations override earlier ones, so
  // the scan runs from the farthest offset down to offset zero.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  assign pick      = rr_pick(req_valid, ptr_q);
  assign gnt_found = pick[ID_W];
  assign gnt_idx   = pick[ID_W-1:0];

  assign alu_a   = req_a[gnt_idx*32 +: 32];
  assign alu_b   = req_b[gnt_idx*32 +: 32];
  assign alu_sel = req_sel[gnt_idx*3 +: 3];

  alu_share_arbiter_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Grant is suppressed while reset is held so no requester sees a handshake.
  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    req_ready  = '0;
    if (rst_n && can_accept && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy_cnt   <= '0;
      ptr_q      <= '0;
    end else if (accept) begin
      rsp_id     <= gnt_idx;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      busy_cnt   <= busy_cnt + 32'd1;
      ptr_q      <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
